bsg_manycore_pkt_receive: RTL and testbench
===========================================

// Module: bsg_manycore_pkt_receive
// PURPOSE
//  Endpoint receiver for manycore network packets built by the tile-side packet encoder.
//  - Buffers incoming packets in a small FIFO.
//  - Decodes each packet into a local-memory byte-masked store or a tile config write.
//  - Returns one credit per consumed packet toward the sender.
//  - Sits between the network input link and the tile's local data memory.
// PARAMETERS
//  x_cord_width_p   "inv"  width of x coordinate fields
//  y_cord_width_p   "inv"  width of y coordinate fields
//  data_width_p     "inv"  packet data width; mask width is data_width_p>>3
//  addr_width_p     "inv"  packet addr field width
//  fifo_els_p       2      input buffer depth (>=2)
//  freeze_init_p    1      reset value of freeze_o
//  packet_width_lp  derived  `bsg_manycore_packet_width(addr,data,x,y)
// PORTS
//  clk_i          in   1               clock
//  reset_i        in   1               asynchronous, active-high reset
//  v_i            in   1               incoming packet valid
//  data_i         in   packet_width_lp packet, bsg_manycore_packet_s layout
//  ready_o        out  1               buffer can accept (= not full)
//  my_x_i         in   x_cord_width_p  this tile's x coordinate
//  my_y_i         in   y_cord_width_p  this tile's y coordinate
//  mem_v_o        out  1               local memory store request
//  mem_addr_o     out  addr_width_p    store word address (pkt.addr)
//  mem_data_o     out  data_width_p    store data (pkt.data)
//  mem_mask_o     out  data_width_p>>3 byte enables (pkt.op_ex)
//  mem_yumi_i     in   1               memory accepts request this cycle
//  freeze_o       out  1               tile freeze config bit
//  credit_v_o     out  1               one-cycle pulse: one packet consumed
//  store_count_o  out  16              count of completed memory stores, wraps
//  error_o        out  1               sticky: bad op or misrouted packet seen
// BEHAVIOUR
//  Reset values:
//   - ready_o=1 once out of reset, FIFO empty, mem_v_o=0, credit_v_o=0.
//   - store_count_o=0, error_o=0, freeze_o=freeze_init_p.
//  Enqueue: push when v_i & ready_o. ready_o=0 iff count==fifo_els_p.
//   - No bypass: packet pushed in cycle N is earliest head-visible in N+1.
//  Push and pop in the same cycle are allowed when not full; count is unchanged.
//  Head decode, evaluated only when the FIFO is non-empty:
//   - Misroute: x_cord!=my_x_i or y_cord!=my_y_i -> pop immediately, set error_o, credit pulse.
//   - op==2'b01 (store): mem_v_o=1 with addr/data/mask from head.
//     * Outputs held stable until mem_yumi_i.
//     * On yumi: pop, store_count_o+=1 (mod 2^16), credit pulse.
//     * mem_yumi_i while mem_v_o=0 is ignored.
//   - op==2'b10 (config): pop the same cycle, no memory request.
//     * addr==0: freeze_o<=data[0] next cycle.
//     * Other addr: ignored, not an error.
//     * Credit pulse.
//   - op 2'b00/2'b11: pop, set error_o, credit pulse, no side effect.
//  Misroute check has priority over op decode.
//  credit_v_o: registered; asserted in cycle N+1 for each pop in cycle N.
//   - At most one pop per cycle, so back-to-back pops give back-to-back pulses.
//  Throughput: one packet per cycle when mem_yumi_i is held high.
//  mem_v_o is combinational from FIFO state only; it must not depend on mem_yumi_i.
//  error_o clears only on reset.
//  Reset mid-operation: FIFO is flushed.
//   - Any in-flight mem request is dropped, no credit for flushed packets.
//   - freeze_o returns to freeze_init_p.
// TESTING
//  1. Store to (my_x,my_y), addr=0x10, data=0xDEADBEEF, mask=4'b0011, yumi same cycle it is offered
//     -> mem_v_o one cycle later with those values; credit_v_o next cycle; store_count_o=1.
//  2. Hold mem_yumi_i=0, send 3 packets with fifo_els_p=2 -> ready_o=0 after 2 pushes;
//     mem outputs stable. Then release yumi -> 2 stores in consecutive cycles, 2 credit pulses.
//  3. Config op addr=0 data=0 after reset -> freeze_o 1->0, no mem_v_o, one credit pulse.
//     Repeat with data=1 -> freeze_o=1.
//  4. Packet with x_cord=my_x_i+1 -> no mem_v_o, error_o=1 sticky, credit pulse.
//     Also op=2'b11 -> same response.
//  5. Preload store_count_o to 0xFFFF via 65535 stores, one more store -> store_count_o=0.
//  6. Assert reset_i while mem_v_o=1 and FIFO full -> mem_v_o=0, ready_o=1, no credit pulses;
//     a following store completes normally.

Source files
------------

// File: rtl/bsg_manycore_pkt_receive.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : bsg_manycore_pkt_receive
// Brief    : Manycore network endpoint. Buffers packets, issues byte-masked
//            local stores or tile config writes, returns one credit per packet.
// Revision : 1.0
//------------------------------------------------------------------------------
module bsg_manycore_pkt_receive #(
   parameter int x_cord_width_p  = 4,
   parameter int y_cord_width_p  = 4,
   parameter int data_width_p    = 32,
   parameter int addr_width_p    = 16,
   parameter int fifo_els_p      = 2,
   parameter bit freeze_init_p   = 1'b1,
   parameter int packet_width_lp = addr_width_p + 2 + (data_width_p >> 3)
                                 + data_width_p + y_cord_width_p + x_cord_width_p
) (
   input  logic                           clk_i,
   input  logic                           reset_i,

   input  logic                           v_i,
   input  logic [packet_width_lp-1:0]     data_i,
   output logic                           ready_o,

   input  logic [x_cord_width_p-1:0]      my_x_i,
   input  logic [y_cord_width_p-1:0]      my_y_i,

   output logic                           mem_v_o,
   output logic [addr_width_p-1:0]        mem_addr_o,
   output logic [data_width_p-1:0]        mem_data_o,
   output logic [(data_width_p>>3)-1:0]   mem_mask_o,
   input  logic                           mem_yumi_i,

   output logic                           freeze_o,
   output logic                           credit_v_o,
   output logic [15:0]                    store_count_o,
   output logic                           error_o
);

   localparam int c_mask_w = data_width_p >> 3;
   localparam int c_ptr_w  = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
   localparam int c_cnt_w  = $clog2(fifo_els_p + 1);

   // Packet layout, LSB upward: x_cord, y_cord, data, op_ex (mask), op, addr
   localparam int c_y_lsb    = x_cord_width_p;
   localparam int c_data_lsb = c_y_lsb + y_cord_width_p;
   localparam int c_mask_lsb = c_data_lsb + data_width_p;
   localparam int c_op_lsb   = c_mask_lsb + c_mask_w;
   localparam int c_addr_lsb = c_op_lsb + 2;

   localparam logic [1:0]         c_op_store   = 2'b01;
   localparam logic [1:0]         c_op_config  = 2'b10;
   localparam logic [c_ptr_w-1:0] c_last_ptr   = c_ptr_w'(fifo_els_p - 1);
   localparam logic [c_cnt_w-1:0] c_full_count = c_cnt_w'(fifo_els_p);

   logic [packet_width_lp-1:0] r_buf [fifo_els_p];
   logic [c_ptr_w-1:0]         r_rd_ptr;
   logic [c_ptr_w-1:0]         r_wr_ptr;
   logic [c_cnt_w-1:0]         r_count;
   logic                       r_credit;
   logic                       r_error;
   logic                       r_freeze;
   logic [15:0]                r_store_count;

   logic                       w_not_full;
   logic                       w_nonempty;
   logic                       w_push;
   logic                       w_pop;
   logic [packet_width_lp-1:0] w_head;
   logic [x_cord_width_p-1:0]  w_head_x;
   logic [y_cord_width_p-1:0]  w_head_y;
   logic [data_width_p-1:0]    w_head_data;
   logic [c_mask_w-1:0]        w_head_mask;
   logic [1:0]                 w_head_op;
   logic [addr_width_p-1:0]    w_head_addr;
   logic                       w_routed;
   logic                       w_is_store;
   logic                       w_is_config;
   logic                       w_is_bad;
   logic                       w_store_done;

   function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] p);
      next_ptr = (p == c_last_ptr) ? '0 : p + 1'b1;
   endfunction

   // ---------------------------------------------------------------- buffer
   assign w_not_full = (r_count != c_full_count);
   assign w_nonempty = (r_count != '0);
   assign w_push     = v_i & w_not_full;
   assign ready_o    = w_not_full;

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_buf[r_wr_ptr] <= data_i;
      end
   end

   // ---------------------------------------------------------------- decode
   assign w_head      = r_buf[r_rd_ptr];
   assign w_head_x    = w_head[0 +: x_cord_width_p];
   assign w_head_y    = w_head[c_y_lsb +: y_cord_width_p];
   assign w_head_data = w_head[c_data_lsb +: data_width_p];
   assign w_head_mask = w_head[c_mask_lsb +: c_mask_w];
   assign w_head_op   = w_head[c_op_lsb +: 2];
   assign w_head_addr = w_head[c_addr_lsb +: addr_width_p];

   // Misrouting overrides whatever the opcode says.
   assign w_routed     = (w_head_x == my_x_i) && (w_head_y == my_y_i);
   assign w_is_store   = w_nonempty & w_routed & (w_head_op == c_op_store);
   assign w_is_config  = w_nonempty & w_routed & (w_head_op == c_op_config);
   assign w_is_bad     = w_nonempty & ~(w_is_store | w_is_config);
   assign w_store_done = w_is_store & mem_yumi_i;
   assign w_pop        = w_store_done | w_is_config | w_is_bad;

   assign mem_v_o    = w_is_store;
   assign mem_addr_o = w_head_addr;
   assign mem_data_o = w_head_data;
   assign mem_mask_o = w_head_mask;

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_count       <= '0;
         r_credit      <= 1'b0;
         r_error       <= 1'b0;
         r_freeze      <= freeze_init_p;
         r_store_count <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= next_ptr(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= next_ptr(r_rd_ptr);
         end

         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase

         r_credit <= w_pop;

         if (w_store_done) begin
            r_store_count <= r_store_count + 16'd1;
         end

         if (w_is_bad) begin
            r_error <= 1'b1;
         end

         // Only config address 0 is defined; other addresses are silently dropped.
         if (w_is_config && (w_head_addr == '0)) begin
            r_freeze <= w_head_data[0];
         end
      end
   end

   assign credit_v_o    = r_credit;
   assign error_o       = r_error;
   assign freeze_o      = r_freeze;
   assign store_count_o = r_store_count;

endmodule
`default_nettype wire

// File: tb/tb_bsg_manycore_pkt_receive.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_bsg_manycore_pkt_receive
// Brief    : Self-checking bench: vector table, corner sequences, random vs model.
// Revision : 1.0
//------------------------------------------------------------------------------
module tb_bsg_manycore_pkt_receive;

   localparam int XW  = 4;
   localparam int YW  = 4;
   localparam int DW  = 32;
   localparam int AW  = 16;
   localparam int MW  = DW >> 3;
   localparam int ELS = 2;
   localparam int PW  = AW + 2 + MW + DW + YW + XW;

   localparam logic [XW-1:0] MY_X = 4'h3;
   localparam logic [YW-1:0] MY_Y = 4'h5;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [1:0]    op;
      logic [MW-1:0] mask;
      logic [DW-1:0] data;
      logic [YW-1:0] y;
      logic [XW-1:0] x;
   } pkt_t;

   typedef struct {
      logic [1:0]    op;
      logic          bad_route;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [MW-1:0] mask;
      logic          exp_mem_v;
      logic          exp_err;
      logic          exp_frz;
      logic [15:0]   exp_cnt;
   } vec_t;

   logic          clk;
   logic          reset;
   logic          v;
   logic [PW-1:0] data;
   logic          ready;
   logic          mem_v;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic [MW-1:0] mem_mask;
   logic          yumi;
   logic          freeze;
   logic          credit;
   logic [15:0]   store_count;
   logic          error;

   int n_checks;
   int n_errors;

   bsg_manycore_pkt_receive #(
      .x_cord_width_p (XW),
      .y_cord_width_p (YW),
      .data_width_p   (DW),
      .addr_width_p   (AW),
      .fifo_els_p     (ELS),
      .freeze_init_p  (1'b1)
   ) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .v_i           (v),
      .data_i        (data),
      .ready_o       (ready),
      .my_x_i        (MY_X),
      .my_y_i        (MY_Y),
      .mem_v_o       (mem_v),
      .mem_addr_o    (mem_addr),
      .mem_data_o    (mem_data),
      .mem_mask_o    (mem_mask),
      .mem_yumi_i    (yumi),
      .freeze_o      (freeze),
      .credit_v_o    (credit),
      .store_count_o (store_count),
      .error_o       (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic pkt_t mk(input logic [1:0] op, input logic [MW-1:0] mask,
                               input logic [AW-1:0] addr, input logic [DW-1:0] d,
                               input logic [XW-1:0] x, input logic [YW-1:0] y);
      pkt_t p;
      p.addr = addr;
      p.op   = op;
      p.mask = mask;
      p.data = d;
      p.y    = y;
      p.x    = x;
      return p;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      v     = 1'b0;
      yumi  = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   // Reference model state
   pkt_t        mq[$];
   logic        m_err;
   logic        m_frz;
   logic        m_credit;
   logic [15:0] m_cnt;

   vec_t vecs[11];
   pkt_t p;
   pkt_t h;
   logic exp_ready;
   logic exp_mem_v;
   logic pop;
   logic [XW-1:0] xs;
   logic [YW-1:0] ys;
   int   r;

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset = 1'b1;
      v     = 1'b0;
      yumi  = 1'b0;
      data  = '0;

      //            op     bad  addr      data          mask     mv  err frz cnt
      vecs[0]  = '{2'b01, 1'b0, 16'h0010, 32'hDEADBEEF, 4'b0011, 1'b1, 1'b0, 1'b1, 16'd1};
      vecs[1]  = '{2'b10, 1'b0, 16'h0000, 32'h00000000, 4'b0000, 1'b0, 1'b0, 1'b0, 16'd1};
      vecs[2]  = '{2'b10, 1'b0, 16'h0000, 32'h00000001, 4'b0000, 1'b0, 1'b0, 1'b1, 16'd1};
      vecs[3]  = '{2'b10, 1'b0, 16'h0005, 32'h00000000, 4'b0000, 1'b0, 1'b0, 1'b1, 16'd1};
      vecs[4]  = '{2'b01, 1'b0, 16'h0022, 32'h12345678, 4'b1111, 1'b1, 1'b0, 1'b1, 16'd2};
      vecs[5]  = '{2'b01, 1'b0, 16'h0001, 32'h00000000, 4'b1000, 1'b1, 1'b0, 1'b1, 16'd3};
      vecs[6]  = '{2'b01, 1'b1, 16'h0030, 32'hCAFEF00D, 4'b1111, 1'b0, 1'b1, 1'b1, 16'd3};
      vecs[7]  = '{2'b10, 1'b1, 16'h0000, 32'h00000000, 4'b0000, 1'b0, 1'b1, 1'b1, 16'd3};
      vecs[8]  = '{2'b11, 1'b0, 16'h0040, 32'h00000000, 4'b1111, 1'b0, 1'b1, 1'b1, 16'd3};
      vecs[9]  = '{2'b00, 1'b0, 16'h0000, 32'h00000000, 4'b1111, 1'b0, 1'b1, 1'b1, 16'd3};
      vecs[10] = '{2'b01, 1'b0, 16'hFFFF, 32'hFFFFFFFF, 4'b0100, 1'b1, 1'b1, 1'b1, 16'd4};

      // -------- reset state
      do_reset();
      chk("rst_ready",  ready,       1);
      chk("rst_mem_v",  mem_v,       0);
      chk("rst_credit", credit,      0);
      chk("rst_count",  store_count, 0);
      chk("rst_error",  error,       0);
      chk("rst_freeze", freeze,      1);

      // -------- vector table: one packet at a time
      for (int i = 0; i < 11; i++) begin
         p = mk(vecs[i].op, vecs[i].mask, vecs[i].addr, vecs[i].data,
                vecs[i].bad_route ? MY_X + 4'd1 : MY_X, MY_Y);
         data = p;
         v    = 1'b1;
         tick();
         v    = 1'b0;
         yumi = 1'b1;
         chk($sformatf("vec%0d_mem_v", i), mem_v, vecs[i].exp_mem_v);
         if (vecs[i].exp_mem_v) begin
            chk($sformatf("vec%0d_addr", i), mem_addr, vecs[i].addr);
            chk($sformatf("vec%0d_data", i), mem_data, vecs[i].data);
            chk($sformatf("vec%0d_mask", i), mem_mask, vecs[i].mask);
         end
         tick();
         chk($sformatf("vec%0d_credit", i), credit,      1);
         chk($sformatf("vec%0d_error", i),  error,       vecs[i].exp_err);
         chk($sformatf("vec%0d_freeze", i), freeze,      vecs[i].exp_frz);
         chk($sformatf("vec%0d_count", i),  store_count, vecs[i].exp_cnt);
         yumi = 1'b0;
         tick();
         chk($sformatf("vec%0d_credit_off", i), credit, 0);
      end

      // -------- bad opcode alone sets error after a clean reset
      do_reset();
      data = mk(2'b11, 4'hF, 16'h0, 32'h0, MY_X, MY_Y);
      v = 1'b1;
      tick();
      v = 1'b0;
      chk("op11_mem_v", mem_v, 0);
      tick();
      chk("op11_error",  error,  1);
      chk("op11_credit", credit, 1);
      tick();
      tick();
      chk("op11_sticky", error, 1);

      // -------- backpressure: fill, stall, then drain back-to-back
      do_reset();
      data = mk(2'b01, 4'hF, 16'h0100, 32'hA0A0A0A0, MY_X, MY_Y);
      v = 1'b1;
      tick();
      chk("bp_ready1", ready,    1);
      chk("bp_mem_v1", mem_v,    1);
      chk("bp_addrA",  mem_addr, 16'h0100);
      data = mk(2'b01, 4'h1, 16'h0101, 32'hB1B1B1B1, MY_X, MY_Y);
      tick();
      chk("bp_full",   ready,    0);
      chk("bp_holdA1", mem_addr, 16'h0100);
      data = mk(2'b01, 4'h2, 16'h0102, 32'hC2C2C2C2, MY_X, MY_Y);
      tick();
      chk("bp_full2",  ready,    0);
      chk("bp_holdA2", mem_data, 32'hA0A0A0A0);
      tick();
      chk("bp_holdA3", mem_addr, 16'h0100);
      chk("bp_nocred", credit,   0);
      yumi = 1'b1;
      tick();
      chk("bp_cred1",  credit,      1);
      chk("bp_addrB",  mem_addr,    16'h0101);
      chk("bp_cnt1",   store_count, 1);
      chk("bp_ready2", ready,       1);
      tick();
      chk("bp_cred2",  credit,      1);
      chk("bp_cnt2",   store_count, 2);
      chk("bp_addrC",  mem_addr,    16'h0102);
      v = 1'b0;
      tick();
      chk("bp_cred3",  credit,      1);
      chk("bp_cnt3",   store_count, 3);
      chk("bp_empty",  mem_v,       0);
      yumi = 1'b0;
      tick();
      chk("bp_credoff", credit, 0);

      // -------- reset while full with a store pending
      do_reset();
      data = mk(2'b10, 4'h0, 16'h0, 32'h0, MY_X, MY_Y);
      v = 1'b1;
      tick();
      data = mk(2'b01, 4'hF, 16'h0200, 32'h11111111, MY_X, MY_Y);
      tick();
      data = mk(2'b01, 4'hF, 16'h0201, 32'h22222222, MY_X, MY_Y);
      tick();
      v = 1'b0;
      chk("mr_frz0",  freeze, 0);
      chk("mr_full",  ready,  0);
      chk("mr_mem_v", mem_v,  1);
      #2;
      reset = 1'b1;
      #1;
      chk("mr_async_mem_v", mem_v,  0);
      chk("mr_async_ready", ready,  1);
      chk("mr_async_frz",   freeze, 1);
      tick();
      reset = 1'b0;
      chk("mr_nocred1", credit, 0);
      tick();
      chk("mr_nocred2", credit, 0);
      chk("mr_mem_v2",  mem_v,  0);
      data = mk(2'b01, 4'h5, 16'h0300, 32'h33333333, MY_X, MY_Y);
      v = 1'b1;
      tick();
      v = 1'b0;
      yumi = 1'b1;
      chk("mr_post_addr", mem_addr, 16'h0300);
      tick();
      chk("mr_post_cred", credit,      1);
      chk("mr_post_cnt",  store_count, 1);
      yumi = 1'b0;

      // -------- store counter wrap at one store per cycle
      do_reset();
      data = mk(2'b01, 4'hF, 16'h0004, 32'h5A5A5A5A, MY_X, MY_Y);
      v    = 1'b1;
      yumi = 1'b1;
      for (int i = 0; i < 65535; i++) tick();
      v = 1'b0;
      tick();
      chk("wrap_ffff", store_count, 16'hFFFF);
      v = 1'b1;
      tick();
      v = 1'b0;
      tick();
      chk("wrap_zero",   store_count, 16'h0000);
      chk("wrap_credit", credit,      1);
      yumi = 1'b0;

      // -------- random traffic against queue model
      do_reset();
      mq.delete();
      m_err    = 1'b0;
      m_frz    = 1'b1;
      m_credit = 1'b0;
      m_cnt    = '0;
      for (int c = 0; c < 3000; c++) begin
         r  = $urandom_range(0, 9);
         xs = ($urandom_range(0, 9) == 0) ? MY_X ^ XW'($urandom_range(1, 15)) : MY_X;
         ys = ($urandom_range(0, 9) == 0) ? MY_Y ^ YW'($urandom_range(1, 15)) : MY_Y;
         p  = mk((r < 6) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11,
                 MW'($urandom), ($urandom_range(0, 2) == 0) ? '0 : AW'($urandom),
                 DW'($urandom), xs, ys);
         data = p;
         v    = ($urandom_range(0, 3) != 0);
         yumi = ($urandom_range(0, 2) != 0);
         #1;

         exp_ready = (mq.size() < ELS);
         exp_mem_v = 1'b0;
         if (mq.size() > 0) begin
            h = mq[0];
            exp_mem_v = (h.x == MY_X) && (h.y == MY_Y) && (h.op == 2'b01);
         end
         chk("rnd_ready",  ready,       exp_ready);
         chk("rnd_mem_v",  mem_v,       exp_mem_v);
         chk("rnd_credit", credit,      m_credit);
         chk("rnd_error",  error,       m_err);
         chk("rnd_freeze", freeze,      m_frz);
         chk("rnd_count",  store_count, m_cnt);
         if (exp_mem_v) begin
            chk("rnd_addr", mem_addr, h.addr);
            chk("rnd_data", mem_data, h.data);
            chk("rnd_mask", mem_mask, h.mask);
         end

         pop = 1'b0;
         if (mq.size() > 0) begin
            h = mq[0];
            if (h.x != MY_X || h.y != MY_Y) begin
               pop = 1'b1;
               m_err = 1'b1;
            end else if (h.op == 2'b01) begin
               if (yumi) begin
                  pop = 1'b1;
                  m_cnt = m_cnt + 16'd1;
               end
            end else if (h.op == 2'b10) begin
               pop = 1'b1;
               if (h.addr == '0) m_frz = h.data[0];
            end else begin
               pop = 1'b1;
               m_err = 1'b1;
            end
         end
         if (pop) void'(mq.pop_front());
         if (v && exp_ready) mq.push_back(p);
         m_credit = pop;
         tick();
      end
      v    = 1'b0;
      yumi = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
